// File: rtl/compare_seq_ctrl_pkg.sv
// Shared types and helpers for the serial word comparator sequencer.
package compare_seq_ctrl_pkg;

  // Sequencer states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a bit index into a word of the given width, never less than one bit.
  function automatic int calc_idxw(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/compare_seq_ctrl_cmp.sv
// Single-bit equality cell shared with the rest of the control path.
module compare_seq_ctrl_cmp (
  input  logic a,
  input  logic b,
  output logic equal
);

  assign equal = ~(a ^ b);

endmodule

// File: rtl/compare_seq_ctrl.sv
// Serial LSB-first word comparator sequencer with start/busy/done handshake.
// Reports whether two words are identical and the lowest differing bit.
module compare_seq_ctrl
  import compare_seq_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int IDXW      = calc_idxw(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDXW-1:0]  mismatch_idx
);

  // One extra counter bit so counting up to WIDTH never wraps for power-of-two widths.
  localparam int CNTW = IDXW + 1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNTW-1:0]  bit_cnt;
  logic             miss;
  logic [IDXW-1:0]  miss_idx;
  logic             eq_bit;
  logic             last_bit;
  logic             stop_early;

  compare_seq_ctrl_cmp u_cmp (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .equal (eq_bit)
  );

  assign last_bit   = (bit_cnt == CNTW'(WIDTH - 1));
  assign stop_early = (EARLY_EXIT != 0) && !eq_bit;
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

  // State register; reset wins over everything and drops any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode: accept only from IDLE, leave RUN on the last bit or an early mismatch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (stop_early || last_bit) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN cycle, latch results on the way into DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh         <= '0;
      b_sh         <= '0;
      bit_cnt      <= '0;
      miss         <= 1'b0;
      miss_idx     <= '0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh         <= a_word;
            b_sh         <= b_word;
            bit_cnt      <= '0;
            miss         <= 1'b0;
            miss_idx     <= '0;
            equal        <= 1'b0;
            mismatch_idx <= '0;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (!eq_bit && !miss) begin
            miss     <= 1'b1;
            miss_idx <= bit_cnt[IDXW-1:0];
          end
          if (next_state == ST_DONE) begin
            equal <= !miss && eq_bit;
            if (miss)        mismatch_idx <= miss_idx;
            else if (!eq_bit) mismatch_idx <= bit_cnt[IDXW-1:0];
            else             mismatch_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Self-checking bench: one early-exit and one full-scan instance driven with identical stimulus.
module tb_compare_seq_ctrl;

  localparam int WIDTH = 8;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] a_word;
  logic [7:0] b_word;

  logic       busy_e, done_e, equal_e;
  logic [2:0] idx_e;
  logic       busy_f, done_f, equal_f;
  logic [2:0] idx_f;

  logic       busy_v  [2];
  logic       done_v  [2];
  logic       equal_v [2];
  logic [2:0] idx_v   [2];

  int vectors = 0;
  int misses  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         eq;
    int         idx;
    int         lat_e;
    int         lat_f;
  } vec_t;

  vec_t tbl[8];

  compare_seq_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(1)) dut_e (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .a_word       (a_word),
    .b_word       (b_word),
    .busy         (busy_e),
    .done         (done_e),
    .equal        (equal_e),
    .mismatch_idx (idx_e)
  );

  compare_seq_ctrl #(.WIDTH(WIDTH), .EARLY_EXIT(0)) dut_f (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .a_word       (a_word),
    .b_word       (b_word),
    .busy         (busy_f),
    .done         (done_f),
    .equal        (equal_f),
    .mismatch_idx (idx_f)
  );

  assign busy_v[0]  = busy_e;
  assign busy_v[1]  = busy_f;
  assign done_v[0]  = done_e;
  assign done_v[1]  = done_f;
  assign equal_v[0] = equal_e;
  assign equal_v[1] = equal_f;
  assign idx_v[0]   = idx_e;
  assign idx_v[1]   = idx_f;

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #10;
  endtask

  // Reference: equality and lowest differing bit from plain word arithmetic.
  task automatic modelOp(input logic [7:0] a, input logic [7:0] b,
                         output bit eq, output int idx, output int lat_e, output int lat_f);
    logic [7:0] diff;
    diff = a ^ b;
    eq   = (diff == 8'h00);
    idx  = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (diff[i]) idx = i;
    lat_f = WIDTH;
    lat_e = eq ? WIDTH : idx + 1;
  endtask

  // One operation on both instances; operands are scrambled after accept; hold keeps start high.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit eq,
                               input int idx, input int lat_e, input int lat_f,
                               input bit hold, input string tag);
    int  lat[2], busy_cnt[2], pulses[2], exp_lat[2];
    bit  got[2], reacc[2];
    int  eq_s[2], idx_s[2];
    exp_lat[0] = lat_e;
    exp_lat[1] = lat_f;
    for (int d = 0; d < 2; d++) begin
      lat[d] = 0; busy_cnt[d] = 0; pulses[d] = 0; got[d] = 0; reacc[d] = 0;
      eq_s[d] = -1; idx_s[d] = -1;
    end
    a_word = a;
    b_word = b;
    start  = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) busy_cnt[d] = int'(busy_v[d]);
    if (!hold) start = 1'b0;
    for (int cyc = 1; cyc <= WIDTH + 3; cyc++) begin
      a_word = 8'($urandom);
      b_word = 8'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        if (done_v[d]) pulses[d]++;
        if (!got[d]) begin
          if (done_v[d]) begin
            got[d]   = 1'b1;
            lat[d]   = cyc;
            eq_s[d]  = int'(equal_v[d]);
            idx_s[d] = int'(idx_v[d]);
          end else begin
            busy_cnt[d] += int'(busy_v[d]);
          end
        end else if (cyc == lat[d] + 2) begin
          reacc[d] = busy_v[d];
        end
      end
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      string who;
      who = (d == 0) ? "early" : "full";
      checkOutput($sformatf("%s %s latency", tag, who), lat[d], exp_lat[d]);
      checkOutput($sformatf("%s %s busy cycles", tag, who), busy_cnt[d], exp_lat[d]);
      checkOutput($sformatf("%s %s equal", tag, who), eq_s[d], int'(eq));
      checkOutput($sformatf("%s %s mismatch_idx", tag, who), idx_s[d], idx);
      if (hold) checkOutput($sformatf("%s %s reaccept", tag, who), int'(reacc[d]), 1);
      else      checkOutput($sformatf("%s %s done pulses", tag, who), pulses[d], 1);
    end
    for (int i = 0; i < 30 && (busy_e || busy_f || done_e || done_f); i++) tick();
    checkOutput($sformatf("%s return to idle", tag),
                int'(busy_e | busy_f | done_e | done_f), 0);
  endtask

  initial begin
    bit eq;
    int idx, lat_e, lat_f;
    logic [7:0] ra, rb;

    tbl[0] = '{8'hA5, 8'hA5, 1'b1, 0, 8, 8};
    tbl[1] = '{8'hA5, 8'hA1, 1'b0, 2, 3, 8};
    tbl[2] = '{8'h80, 8'h00, 1'b0, 7, 8, 8};
    tbl[3] = '{8'h81, 8'h00, 1'b0, 0, 1, 8};
    tbl[4] = '{8'hFF, 8'hFE, 1'b0, 0, 1, 8};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 0, 8, 8};
    tbl[6] = '{8'h0F, 8'h1F, 1'b0, 4, 5, 8};
    tbl[7] = '{8'h7E, 8'h3C, 1'b0, 1, 2, 8};

    // Reset held with a pending request: nothing may be accepted.
    reset  = 1'b1;
    start  = 1'b1;
    a_word = 8'h00;
    b_word = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("reset%0d busy d%0d", c, d), int'(busy_v[d]), 0);
        checkOutput($sformatf("reset%0d done d%0d", c, d), int'(done_v[d]), 0);
        checkOutput($sformatf("reset%0d equal d%0d", c, d), int'(equal_v[d]), 0);
        checkOutput($sformatf("reset%0d idx d%0d", c, d), int'(idx_v[d]), 0);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    checkOutput("post-reset idle", int'(busy_e | busy_f | done_e | done_f), 0);

    // Table of directed operand pairs.
    for (int i = 0; i < 8; i++)
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].idx, tbl[i].lat_e, tbl[i].lat_f,
                    1'b0, $sformatf("tbl%0d", i));

    // Start held high with operands churning; the captured pair alone decides the result.
    applyStimulus(8'h12, 8'h16, 1'b0, 2, 3, 8, 1'b1, "hold");

    // Reset during the fourth RUN cycle discards the operation.
    applyStimulus(8'hA5, 8'hA5, 1'b1, 0, 8, 8, 1'b0, "pre-reset");
    a_word = 8'h80;
    b_word = 8'h00;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checkOutput("midrun busy early", int'(busy_e), 1);
    checkOutput("midrun busy full", int'(busy_f), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("midrun reset busy d%0d", d), int'(busy_v[d]), 0);
      checkOutput($sformatf("midrun reset done d%0d", d), int'(done_v[d]), 0);
      checkOutput($sformatf("midrun reset equal d%0d", d), int'(equal_v[d]), 0);
      checkOutput($sformatf("midrun reset idx d%0d", d), int'(idx_v[d]), 0);
    end
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        stray += int'(done_e) + int'(done_f) + int'(busy_e) + int'(busy_f);
      end
      checkOutput("no activity after reset", stray, 0);
    end

    // Random pairs against the reference model, with a bias toward equal words.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      modelOp(ra, rb, eq, idx, lat_e, lat_f);
      applyStimulus(ra, rb, eq, idx, lat_e, lat_f, 1'b0, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
